// File: rtl/pe_ctrl_pkg.sv
// Shared types and sizing constants for the PE sequencer control path.
package pe_ctrl_pkg;

    localparam int BYTES_PER_WORD  = 4;
    localparam int FILTER_SIZE_DEF = 16;
    localparam int FILTER_WORDS    = FILTER_SIZE_DEF / BYTES_PER_WORD;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_F,
        CLEAR,
        ACCUM,
        SHIFT,
        FLUSH,
        WRITE,
        FIN
    } pe_state_t;

endpackage

// File: rtl/pe_sequencer.sv
// Control FSM for one PE: filter load, per-window MAC accumulate, and output word packing.
// Outputs decode from registered state/counters; only the valid strobes pass straight through.
module pe_sequencer
    import pe_ctrl_pkg::*;
#(
    parameter int FILTER_SIZE = FILTER_SIZE_DEF,
    parameter int NUM_WINDOWS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           filter_valid,
    input  logic                           window_valid,
    input  logic                           out_ready,
    output logic                           write_filter_buff_en,
    output logic [$clog2(FILTER_SIZE/BYTES_PER_WORD)-1:0] write_filter_buff_ind,
    output logic [$clog2(FILTER_SIZE)-1:0] read_four_to_four_buff_ind,
    output logic                           partial_res_en,
    output logic                           reset_mac,
    output logic                           shift_reg_en,
    output logic                           finalize_shift_reg,
    output logic                           window_ready,
    output logic                           mem_write_en,
    output logic [7:0]                     out_word_addr,
    output logic                           busy,
    output logic                           done
);

    localparam int FW = FILTER_SIZE / BYTES_PER_WORD;
    localparam int IW = $clog2(FILTER_SIZE);
    localparam int WW = $clog2(FW);
    localparam logic [IW-1:0] IDX_LAST = IW'(FILTER_SIZE - 1);
    localparam logic [WW-1:0] FW_LAST  = WW'(FW - 1);
    localparam logic [7:0]    NW       = 8'(NUM_WINDOWS);

    pe_state_t     state;
    logic [WW-1:0] fword;
    logic [IW-1:0] idx;
    logic [1:0]    byte_cnt;
    logic [7:0]    win_cnt;
    logic [7:0]    addr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            fword    <= '0;
            idx      <= '0;
            byte_cnt <= '0;
            win_cnt  <= '0;
            addr     <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    state <= LOAD_F;
                    fword <= '0;
                end
                LOAD_F: if (filter_valid) begin
                    if (fword == FW_LAST) begin
                        fword <= '0;
                        state <= CLEAR;
                    end else begin
                        fword <= fword + 1'b1;
                    end
                end
                CLEAR: begin
                    idx   <= '0;
                    state <= ACCUM;
                end
                ACCUM: if (window_valid) begin
                    if (idx == IDX_LAST) begin
                        idx   <= '0;
                        state <= SHIFT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                // Flush on a full word, or early on the last window for a partial word.
                SHIFT: begin
                    win_cnt  <= win_cnt + 8'd1;
                    byte_cnt <= byte_cnt + 2'd1;
                    state    <= (byte_cnt == 2'd3 || win_cnt + 8'd1 == NW) ? FLUSH : CLEAR;
                end
                FLUSH: state <= WRITE;
                WRITE: if (out_ready) begin
                    addr  <= addr + 8'd1;
                    state <= (win_cnt == NW) ? FIN : CLEAR;
                end
                FIN: begin
                    win_cnt  <= '0;
                    addr     <= '0;
                    byte_cnt <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign write_filter_buff_en       = (state == LOAD_F) && filter_valid;
    assign write_filter_buff_ind      = fword;
    assign read_four_to_four_buff_ind = idx;
    assign window_ready               = (state == ACCUM) && window_valid;
    assign partial_res_en             = window_ready;
    assign reset_mac                  = (state == CLEAR);
    assign shift_reg_en               = (state == SHIFT);
    assign finalize_shift_reg         = (state == FLUSH);
    assign mem_write_en               = (state == WRITE);
    assign out_word_addr              = addr;
    assign busy                       = (state != IDLE);
    assign done                       = (state == FIN);

endmodule

// File: tb/tb_pe_sequencer.sv
// Scoreboard bench for pe_sequencer: two instances (8 and 6 windows), directed jobs.
module tb_pe_sequencer;

    typedef struct {
        int lat;
        int clr;
        int sh;
        int acc;
    } job_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start8 = 1'b0, start6 = 1'b0;
    logic filter_valid = 1'b1, window_valid = 1'b1, out_ready = 1'b1;

    logic       w8_en, acc8, clr8, sh8, fin8, wr8, mw8, busy8, done8;
    logic [1:0] w8_ind;
    logic [3:0] r8_ind;
    logic [7:0] addr8;
    logic       w6_en, acc6, clr6, sh6, fin6, wr6, mw6, busy6, done6;
    logic [1:0] w6_ind;
    logic [3:0] r6_ind;
    logic [7:0] addr6;
    logic [22:0] outs8, outs6;

    int n_chk = 0, n_fail = 0;
    int   q8_find[$], q8_addr[$], q8_flush[$];
    job_t q8_job[$];
    int   q6_addr[$], q6_flush[$];
    job_t q6_job[$];

    always #5 clk = ~clk;

    pe_sequencer #(.FILTER_SIZE(16), .NUM_WINDOWS(8)) dut (
        .clk(clk), .rst(rst), .start(start8), .filter_valid(filter_valid),
        .window_valid(window_valid), .out_ready(out_ready),
        .write_filter_buff_en(w8_en), .write_filter_buff_ind(w8_ind),
        .read_four_to_four_buff_ind(r8_ind), .partial_res_en(acc8), .reset_mac(clr8),
        .shift_reg_en(sh8), .finalize_shift_reg(fin8), .window_ready(wr8),
        .mem_write_en(mw8), .out_word_addr(addr8), .busy(busy8), .done(done8)
    );

    pe_sequencer #(.FILTER_SIZE(16), .NUM_WINDOWS(6)) dut6 (
        .clk(clk), .rst(rst), .start(start6), .filter_valid(filter_valid),
        .window_valid(window_valid), .out_ready(out_ready),
        .write_filter_buff_en(w6_en), .write_filter_buff_ind(w6_ind),
        .read_four_to_four_buff_ind(r6_ind), .partial_res_en(acc6), .reset_mac(clr6),
        .shift_reg_en(sh6), .finalize_shift_reg(fin6), .window_ready(wr6),
        .mem_write_en(mw6), .out_word_addr(addr6), .busy(busy6), .done(done6)
    );

    assign outs8 = {w8_en, w8_ind, r8_ind, acc8, clr8, sh8, fin8, wr8, mw8, addr8, busy8, done8};
    assign outs6 = {w6_en, w6_ind, r6_ind, acc6, clr6, sh6, fin6, wr6, mw6, addr6, busy6, done6};

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event with no expectation or timeout", name);
    endtask

    // Monitor for the 8-window instance.
    initial begin
        int jc, nclr, nsh, nacc, nsf;
        job_t j;
        jc = 0; nclr = 0; nsh = 0; nacc = 0; nsf = 0;
        forever begin
            @(negedge clk); #2;
            if (!rst) begin
                jc = 0; nclr = 0; nsh = 0; nacc = 0; nsf = 0;
                continue;
            end
            if (busy8) jc++;
            if (clr8) nclr++;
            if (acc8) nacc++;
            if (sh8) begin nsh++; nsf++; end
            if (w8_en) begin
                if (q8_find.size() == 0) fail_now("filter_ind8");
                else check("filter_ind8", int'(w8_ind), q8_find.pop_front());
            end
            if (fin8) begin
                if (q8_flush.size() == 0) fail_now("shifts_per_word8");
                else check("shifts_per_word8", nsf, q8_flush.pop_front());
                nsf = 0;
            end
            if (mw8 && out_ready) begin
                if (q8_addr.size() == 0) fail_now("mem_addr8");
                else check("mem_addr8", int'(addr8), q8_addr.pop_front());
            end
            if (done8) begin
                if (q8_job.size() == 0) fail_now("done8");
                else begin
                    j = q8_job.pop_front();
                    check("done_latency8", jc, j.lat);
                    check("reset_mac_count8", nclr, j.clr);
                    check("shift_count8", nsh, j.sh);
                    check("accum_count8", nacc, j.acc);
                end
                jc = 0; nclr = 0; nsh = 0; nacc = 0; nsf = 0;
            end
        end
    end

    // Monitor for the 6-window instance.
    initial begin
        int jc, nclr, nsh, nsf;
        job_t j;
        jc = 0; nclr = 0; nsh = 0; nsf = 0;
        forever begin
            @(negedge clk); #2;
            if (!rst) begin
                jc = 0; nclr = 0; nsh = 0; nsf = 0;
                continue;
            end
            if (busy6) jc++;
            if (clr6) nclr++;
            if (sh6) begin nsh++; nsf++; end
            if (fin6) begin
                if (q6_flush.size() == 0) fail_now("shifts_per_word6");
                else check("shifts_per_word6", nsf, q6_flush.pop_front());
                nsf = 0;
            end
            if (mw6 && out_ready) begin
                if (q6_addr.size() == 0) fail_now("mem_addr6");
                else check("mem_addr6", int'(addr6), q6_addr.pop_front());
            end
            if (done6) begin
                if (q6_job.size() == 0) fail_now("done6");
                else begin
                    j = q6_job.pop_front();
                    check("done_latency6", jc, j.lat);
                    check("reset_mac_count6", nclr, j.clr);
                    check("shift_count6", nsh, j.sh);
                end
                jc = 0; nclr = 0; nsh = 0; nsf = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_filter8();
        for (int i = 0; i < 4; i++) q8_find.push_back(i);
    endtask

    task automatic push8(input int lat);
        push_filter8();
        q8_addr.push_back(0);
        q8_addr.push_back(1);
        q8_flush.push_back(4);
        q8_flush.push_back(4);
        q8_job.push_back('{lat: lat, clr: 8, sh: 8, acc: 128});
    endtask

    task automatic go(input bit six);
        if (six) start6 = 1'b1; else start8 = 1'b1;
        @(negedge clk);
        start6 = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic wait_done(input bit six);
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk); #1;
            if (six ? done6 : done8) break;
        end
        if (k == 400) fail_now(six ? "done6_timeout" : "done8_timeout");
        tick(2);
    endtask

    task automatic wait_idx8(input int v);
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (int'(r8_ind) == v && busy8) break;
        end
        if (k == 400) fail_now("idx_wait_timeout");
    endtask

    initial begin
        int k;
        // Reset state
        tick(3); #1;
        check("reset_outs8", int'(outs8), 0);
        check("reset_outs6", int'(outs6), 0);
        @(negedge clk);
        rst = 1'b1;
        tick(1);

        // Baseline 8-window job
        push8(153);
        go(1'b0);
        wait_done(1'b0);

        // Window stall of 3 cycles at idx 5
        push8(156);
        go(1'b0);
        wait_idx8(5);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            window_valid = 1'b0;
            #1;
            check("stall_idx", int'(r8_ind), 5);
            check("stall_accum_en", int'(acc8), 0);
            check("stall_window_ready", int'(wr8), 0);
        end
        @(negedge clk);
        window_valid = 1'b1;
        wait_done(1'b0);

        // Output backpressure for 5 cycles in the first WRITE
        push8(158);
        go(1'b0);
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (mw8) break;
        end
        if (k == 400) fail_now("write_wait_timeout");
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            out_ready = 1'b0;
            #1;
            check("bp_mem_write_en", int'(mw8), 1);
            check("bp_no_reset_mac", int'(clr8), 0);
            check("bp_addr", int'(addr8), 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        wait_done(1'b0);

        // Partial last word with 6 windows
        q6_addr.push_back(0);
        q6_addr.push_back(1);
        q6_flush.push_back(4);
        q6_flush.push_back(2);
        q6_job.push_back('{lat: 117, clr: 6, sh: 6, acc: 0});
        go(1'b1);
        wait_done(1'b1);

        // Reset mid-ACCUM aborts; restart reloads filter from slot 0
        push_filter8();
        go(1'b0);
        wait_idx8(9);
        rst = 1'b0;
        @(negedge clk); #1;
        check("abort_outs", int'(outs8), 0);
        check("abort_busy", int'(busy8), 0);
        rst = 1'b1;
        tick(1);
        push8(153);
        go(1'b0);
        wait_done(1'b0);

        // start pulse mid-job is ignored
        push8(153);
        go(1'b0);
        wait_idx8(3);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        #1;
        check("start_ignored_busy", int'(busy8), 1);
        check("start_ignored_idx", int'(r8_ind), 4);
        wait_done(1'b0);

        check("q8_drained", q8_find.size() + q8_addr.size() + q8_flush.size() + q8_job.size(), 0);
        check("q6_drained", q6_addr.size() + q6_flush.size() + q6_job.size(), 0);
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
